// File: rtl/add_sub_align_shf_pipe.sv
// Pipelined LSR/ASR/LSL barrel shifter for FPU add/sub alignment, with valid/ready back-pressure.
// Optional o_sticky output (OR of right-shifted-out bits) is enabled by defining ADD_SUB_SHF_STICKY_EN.
`timescale 1ns/1ps

module add_sub_align_shf_pipe #(
  parameter int SIZE_DATA      = 32,
  parameter int SIZE_SHIFT     = 5,
  parameter int STAGES_PER_REG = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_SHIFT-1:0] i_shift_number,
  input  logic [1:0]            i_mode,
  input  logic [SIZE_DATA-1:0]  i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_DATA-1:0]  o_data
`ifdef ADD_SUB_SHF_STICKY_EN
  ,output logic                 o_sticky
`endif
);

  localparam int L = (SIZE_SHIFT + STAGES_PER_REG - 1) / STAGES_PER_REG;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;

  logic [SIZE_DATA-1:0] data_q [L];
  logic [L-1:0]         valid_q;
  logic [L-1:0]         load;
`ifdef ADD_SUB_SHF_STICKY_EN
  logic [L-1:0]         sticky_q;
`endif

  // A stage may load when empty or when the stage after it moves on this cycle.
  always_comb begin
    logic en;
    en          = ~valid_q[L-1] | i_ready;
    load[L-1]   = en;
    for (int k = L - 2; k >= 0; k--) begin
      en      = ~valid_q[k] | en;
      load[k] = en;
    end
  end

  assign o_ready = load[0];
  assign o_valid = valid_q[L-1];
  assign o_data  = data_q[L-1];
`ifdef ADD_SUB_SHF_STICKY_EN
  assign o_sticky = sticky_q[L-1];
`endif

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int LO = k * STAGES_PER_REG;
    localparam int HI = ((k + 1) * STAGES_PER_REG < SIZE_SHIFT) ? (k + 1) * STAGES_PER_REG : SIZE_SHIFT;

    logic                     v_in;
    logic [SIZE_DATA-1:0]     d_in;
    logic [SIZE_DATA-1:0]     d_nxt;
    logic [SIZE_SHIFT-LO-1:0] sh_in;
    logic [1:0]               mode_in;
`ifdef ADD_SUB_SHF_STICKY_EN
    logic                     s_in;
    logic                     s_nxt;
`endif

    if (k == 0) begin : g_src
      assign v_in    = i_valid;
      assign d_in    = i_data;
      assign sh_in   = i_shift_number;
      assign mode_in = i_mode;
`ifdef ADD_SUB_SHF_STICKY_EN
      assign s_in    = 1'b0;
`endif
    end else begin : g_src
      assign v_in    = valid_q[k-1];
      assign d_in    = data_q[k-1];
      assign sh_in   = g_stage[k-1].g_carry.sh_q;
      assign mode_in = g_stage[k-1].g_carry.mode_q;
`ifdef ADD_SUB_SHF_STICKY_EN
      assign s_in    = sticky_q[k-1];
`endif
    end

    // Mux levels LO..HI-1; a level shifting by >= SIZE_DATA naturally yields full fill.
    always_comb begin
      d_nxt = d_in;
`ifdef ADD_SUB_SHF_STICKY_EN
      s_nxt = s_in;
`endif
      for (int j = LO; j < HI; j++) begin
        if (sh_in[j-LO]) begin
`ifdef ADD_SUB_SHF_STICKY_EN
          if (mode_in != MODE_LSL)
            s_nxt = s_nxt | (|(d_nxt & ~({SIZE_DATA{1'b1}} << (1 << j))));
`endif
          case (mode_in)
            MODE_ASR: d_nxt = $signed(d_nxt) >>> (1 << j);
            MODE_LSL: d_nxt = d_nxt << (1 << j);
            default:  d_nxt = d_nxt >> (1 << j);
          endcase
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
`ifdef ADD_SUB_SHF_STICKY_EN
        sticky_q[k] <= 1'b0;
`endif
      end else if (load[k]) begin
        valid_q[k] <= v_in;
        if (v_in) begin
          data_q[k] <= d_nxt;
`ifdef ADD_SUB_SHF_STICKY_EN
          sticky_q[k] <= s_nxt;
`endif
        end
      end
    end

    // Only the still-unused shift bits and the mode travel to later stages.
    if (k < L - 1) begin : g_carry
      logic [SIZE_SHIFT-HI-1:0] sh_q;
      logic [1:0]               mode_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sh_q   <= '0;
          mode_q <= '0;
        end else if (load[k] && v_in) begin
          sh_q   <= sh_in[SIZE_SHIFT-LO-1:HI-LO];
          mode_q <= mode_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sub_align_shf_pipe.sv
// Self-checking bench for add_sub_align_shf_pipe: vector table, scoreboard, back-pressure and reset cases.
// Sticky checks are compiled in only when ADD_SUB_SHF_STICKY_EN is defined.
`timescale 1ns/1ps

module tb_add_sub_align_shf_pipe;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sh;
    logic [31:0] data;
    logic [31:0] expData;
    logic        expSticky;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [4:0]  i_shift_number = '0;
  logic [1:0]  i_mode = '0;
  logic [31:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        sticky32;

  logic        v24 = 1'b0;
  logic        ordy24;
  logic [4:0]  sh24 = '0;
  logic [1:0]  m24 = '0;
  logic [23:0] d24 = '0;
  logic        ov24;
  logic        rdy24 = 1'b1;
  logic [23:0] od24;
  logic        sticky24;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   popCount = 0;
  int   popFirst = 0;
  int   popLast = 0;
  logic randReady = 1'b0;
  exp_t sb[$];
  vec_t vecs[18];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_sub_align_shf_pipe #(.SIZE_DATA(32), .SIZE_SHIFT(5), .STAGES_PER_REG(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_shift_number(i_shift_number), .i_mode(i_mode), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data)
`ifdef ADD_SUB_SHF_STICKY_EN
    ,.o_sticky(sticky32)
`endif
  );

  add_sub_align_shf_pipe #(.SIZE_DATA(24), .SIZE_SHIFT(5), .STAGES_PER_REG(2)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_valid(v24), .o_ready(ordy24),
    .i_shift_number(sh24), .i_mode(m24), .i_data(d24),
    .o_valid(ov24), .i_ready(rdy24), .o_data(od24)
`ifdef ADD_SUB_SHF_STICKY_EN
    ,.o_sticky(sticky24)
`endif
  );

`ifndef ADD_SUB_SHF_STICKY_EN
  assign sticky32 = 1'b0;
  assign sticky24 = 1'b0;
`endif

  // Reference: shift a 64-bit {data, zeros} window so the low half collects the shifted-out bits.
  function automatic logic [32:0] model(input logic [1:0] m, input logic [4:0] n, input logic [31:0] d);
    logic [63:0] w;
    logic [31:0] r;
    logic        s;
    if (m == 2'b10) begin
      r = d << n;
      s = 1'b0;
    end else begin
      w = {d, 32'h0} >> n;
      r = w[63:32];
      s = |w[31:0];
      if (m == 2'b01 && d[31]) r = r | ~(32'hFFFF_FFFF >> n);
    end
    return {s, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Holds the beat on the inputs until accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [4:0] n, input logic [31:0] d,
                               input logic [31:0] ed, input logic es);
    logic acc;
    int   waited;
    acc    = 1'b0;
    waited = 0;
    i_valid = 1'b1;
    i_mode = m;
    i_shift_number = n;
    i_data = d;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = o_ready;
      if (acc) sb.push_back('{ed, es});
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic checkLatency(input string tag);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_valid_c%0d", tag, i), {31'b0, o_valid}, (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run24(input string tag, input logic [1:0] m, input logic [4:0] n, input logic [23:0] d,
                       input logic [23:0] ed, input logic es);
    int waited;
    v24 = 1'b1;
    m24 = m;
    sh24 = n;
    d24 = d;
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'b0, ordy24}, 32'd1);
    @(posedge clk);
    #1;
    v24 = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ov24 && waited < 20);
    checkOutput({tag, "_valid"}, {31'b0, ov24}, 32'd1);
    checkOutput({tag, "_data"}, {8'h0, od24}, {8'h0, ed});
`ifdef ADD_SUB_SHF_STICKY_EN
    checkOutput({tag, "_sticky"}, {31'b0, sticky24}, {31'b0, es});
`else
    if (es === 1'bx) checkOutput({tag, "_sticky_x"}, 32'd0, 32'd1);
`endif
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transferred beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat got=%h expected=none", o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_data", o_data, e.d);
`ifdef ADD_SUB_SHF_STICKY_EN
        checkOutput("out_sticky", {31'b0, sticky32}, {31'b0, e.s});
`endif
        popCount++;
        if (popCount == 1) popFirst = cyc;
        popLast = cyc;
      end
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle=%0d expected=finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [32:0] r;
    logic [1:0]  m;
    logic [4:0]  n;
    logic [31:0] d;

    vecs[0]  = '{2'b00, 5'd1,  32'h8000_0001, 32'h4000_0000, 1'b1};
    vecs[1]  = '{2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{2'b10, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[3]  = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{2'b11, 5'd4,  32'hF000_0000, 32'h0F00_0000, 1'b0};
    vecs[8]  = '{2'b01, 5'd4,  32'h7FFF_FFFF, 32'h07FF_FFFF, 1'b1};
    vecs[9]  = '{2'b01, 5'd5,  32'hF000_0010, 32'hFF80_0000, 1'b1};
    vecs[10] = '{2'b10, 5'd8,  32'h1234_5678, 32'h3456_7800, 1'b0};
    vecs[11] = '{2'b00, 5'd16, 32'h1234_5678, 32'h0000_1234, 1'b1};
    vecs[12] = '{2'b00, 5'd8,  32'h0000_0100, 32'h0000_0001, 1'b0};
    vecs[13] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[14] = '{2'b01, 5'd30, 32'h4000_0000, 32'h0000_0001, 1'b0};
    vecs[15] = '{2'b10, 5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[16] = '{2'b01, 5'd1,  32'h8000_0001, 32'hC000_0000, 1'b1};
    vecs[17] = '{2'b11, 5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1};

    // Reset state
    #12;
    checkOutput("rst_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_o_data", o_data, 32'd0);
    checkOutput("rst_o_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("rst_o_sticky", {31'b0, sticky32}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat latency");
    applyStimulus(vecs[0].mode, vecs[0].sh, vecs[0].data, vecs[0].expData, vecs[0].expSticky);
    i_valid = 1'b0;
    checkLatency("lat1");
    waitDrain("lat1");

    $display("[TB] vector table streamed back-to-back");
    popCount = 0;
    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i].mode, vecs[i].sh, vecs[i].data, vecs[i].expData, vecs[i].expSticky);
    i_valid = 1'b0;
    waitDrain("stream");
    checkOutput("stream_count", 32'(popCount), 32'd18);
    checkOutput("stream_consecutive", 32'(popLast - popFirst), 32'd17);

    $display("[TB] back-pressure with full pipeline");
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 32'hA5A5_0000 + 32'(i * 32'h1111);
      r = model(2'(i), 5'(i + 3), d);
      applyStimulus(2'(i), 5'(i + 3), d, r[31:0], r[32]);
    end
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_ready_%0d", i), {31'b0, o_ready}, 32'd0);
      checkOutput($sformatf("hold_valid_%0d", i), {31'b0, o_valid}, 32'd1);
      checkOutput($sformatf("hold_data_%0d", i), o_data, sb[0].d);
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    waitDrain("bp");

    $display("[TB] random stream with random back-pressure");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      m = 2'($urandom_range(0, 3));
      n = 5'($urandom_range(0, 31));
      d = $urandom;
      r = model(m, n, d);
      applyStimulus(m, n, d, r[31:0], r[32]);
    end
    i_valid = 1'b0;
    randReady = 1'b0;
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    waitDrain("rand");

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 3; i++) begin
      r = model(2'b00, 5'd2, 32'hFFFF_0000 + 32'(i));
      applyStimulus(2'b00, 5'd2, 32'hFFFF_0000 + 32'(i), r[31:0], r[32]);
    end
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("midrst_o_data", o_data, 32'd0);
    checkOutput("midrst_o_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("midrst_o_sticky", {31'b0, sticky32}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(vecs[9].mode, vecs[9].sh, vecs[9].data, vecs[9].expData, vecs[9].expSticky);
    i_valid = 1'b0;
    checkLatency("lat2");
    waitDrain("postrst");

    $display("[TB] 24-bit instance, out-of-range amounts");
    run24("w24_lsr30", 2'b00, 5'd30, 24'hFF_FFFF, 24'h00_0000, 1'b1);
    run24("w24_asr25", 2'b01, 5'd25, 24'h80_0000, 24'hFF_FFFF, 1'b1);
    run24("w24_lsl24", 2'b10, 5'd24, 24'hFF_FFFF, 24'h00_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
